// File: rtl/alu_md_control_pkg.sv
// Shared codes for the second-generation ALU control: ALU op codes,
// funct field codes (including the multiply/divide group), ALUOp decoder
// codes and the MDU state encoding.
package alu_md_control_pkg;

    // ALUControl codes; low 3 bits of AND/OR/ADD/SUB/SLT match the first generation
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // R-type funct codes
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    // ALUOp codes from the main decoder
    localparam logic [1:0] ALU_DECODER_ADD   = 2'b00;
    localparam logic [1:0] ALU_DECODER_SUB   = 2'b01;
    localparam logic [1:0] ALU_DECODER_FUNCT = 2'b10;
    localparam logic [1:0] ALU_DECODER_OR    = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_FIX  = 2'b11
    } md_state_t;

    // The eight MD functs are 0100xx and 0110xx
    function automatic logic is_md_funct(input logic [5:0] f);
        return (f[5:4] == 2'b01) && !f[2];
    endfunction

endpackage

// File: rtl/alu_md_control_if.sv
// Decode/execute-side bundle for the ALU control and multiply/divide unit.
interface alu_md_control_if #(parameter int WIDTH = 32);
    logic             Valid;
    logic             Flush;
    logic [1:0]       ALUOp;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             MDWrite;
    logic [WIDTH-1:0] MDResult;
    logic             Busy;
    logic             Stall;
    logic             IllegalFunct;

    modport master (
        output Valid, Flush, ALUOp, Funct, SrcA, SrcB,
        input  ALUControl, MDWrite, MDResult, Busy, Stall, IllegalFunct
    );

    modport slave (
        input  Valid, Flush, ALUOp, Funct, SrcA, SrcB,
        output ALUControl, MDWrite, MDResult, Busy, Stall, IllegalFunct
    );
endinterface

// File: rtl/alu_md_control_md_iter.sv
// Iterative multiply/divide datapath: operand magnitudes, 2*WIDTH accumulator
// and step counter. Produces unsigned magnitude results; sign fixup is done
// by the controller.
module alu_md_control_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // mul: {partial, multiplier}; div: {rem, quot}
    logic [CNT_W-1:0]   cnt;
    logic               div_r;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_new;

    assign mag_a = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Shift-add: conditionally add the multiplicand to the upper half, shift right
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: shift in the next dividend bit, subtract if it fits
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, opnd};
    assign rem_new  = rem_ge ? (rem_sh[WIDTH-1:0] - opnd) : rem_sh[WIDTH-1:0];
    assign div_next = {rem_new, acc[WIDTH-2:0], rem_ge};

    // Load on start, then one step per cycle until the counter drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd  <= '0;
            acc   <= '0;
            cnt   <= '0;
            div_r <= 1'b0;
        end else if (start) begin
            opnd  <= mag_b;
            acc   <= {{WIDTH{1'b0}}, mag_a};
            cnt   <= CNT_W'(WIDTH);
            div_r <= op_div;
        end else if (flush) begin
            cnt   <= '0;
        end else if (cnt != '0) begin
            acc   <= div_r ? div_next : mul_next;
            cnt   <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));
    assign hi   = acc[2*WIDTH-1:WIDTH];
    assign lo   = acc[WIDTH-1:0];
endmodule

// File: rtl/alu_md_control.sv
// Second-generation ALU control: Funct/ALUOp decode to a 4-bit ALUControl,
// HI/LO registers, multi-cycle MDU sequencing and the stall request.
module alu_md_control
    import alu_md_control_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            CLK,
    input  logic            RESET_N,
    alu_md_control_if.slave bus
);
    md_state_t        state;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             sg_q, sg_a, dz, op_div_r;

    logic             md_op, busy, stall, go, start, op_signed;
    logic             mt_hi, mt_lo, is_mf;
    logic [3:0]       alu_ctl;
    logic             illegal_f;

    logic               it_done;
    logic [WIDTH-1:0]   it_hi, it_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign md_op     = bus.Valid && (bus.ALUOp == ALU_DECODER_FUNCT) && is_md_funct(bus.Funct);
    assign busy      = (state != MD_IDLE);
    assign stall     = md_op && busy;
    assign go        = md_op && !stall;
    // Flush on the accept edge wins: nothing starts
    assign start     = go && !bus.Flush && (bus.Funct[5:2] == 4'b0110);
    assign op_signed = !bus.Funct[0];
    assign mt_hi     = go && (bus.Funct == FUNCT_MTHI);
    assign mt_lo     = go && (bus.Funct == FUNCT_MTLO);
    assign is_mf     = go && (bus.Funct == FUNCT_MFHI || bus.Funct == FUNCT_MFLO);

    // Funct / ALUOp decode; MD and unknown functs fall back to ADD
    always_comb begin
        alu_ctl   = ALU_ADD;
        illegal_f = 1'b0;
        case (bus.ALUOp)
            ALU_DECODER_ADD: alu_ctl = ALU_ADD;
            ALU_DECODER_SUB: alu_ctl = ALU_SUB;
            ALU_DECODER_OR:  alu_ctl = ALU_OR;
            default: begin
                case (bus.Funct)
                    FUNCT_ADD, FUNCT_ADDU: alu_ctl = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: alu_ctl = ALU_SUB;
                    FUNCT_AND:             alu_ctl = ALU_AND;
                    FUNCT_OR:              alu_ctl = ALU_OR;
                    FUNCT_XOR:             alu_ctl = ALU_XOR;
                    FUNCT_NOR:             alu_ctl = ALU_NOR;
                    FUNCT_SLT:             alu_ctl = ALU_SLT;
                    FUNCT_SLTU:            alu_ctl = ALU_SLTU;
                    FUNCT_SLL:             alu_ctl = ALU_SLL;
                    FUNCT_SRL:             alu_ctl = ALU_SRL;
                    FUNCT_SRA:             alu_ctl = ALU_SRA;
                    default:               illegal_f = !is_md_funct(bus.Funct);
                endcase
            end
        endcase
    end

    alu_md_control_md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .start     (start),
        .flush     (bus.Flush),
        .op_div    (bus.Funct[1]),
        .op_signed (op_signed),
        .src_a     (bus.SrcA),
        .src_b     (bus.SrcB),
        .done      (it_done),
        .hi        (it_hi),
        .lo        (it_lo)
    );

    // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient
    assign prod_fix = sg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    assign quot_fix = dz ? {WIDTH{1'b1}} : (sg_q ? -it_lo : it_lo);
    assign rem_fix  = sg_a ? -it_hi : it_hi;

    // MDU sequencing and HI/LO update
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= MD_IDLE;
            hi_r     <= '0;
            lo_r     <= '0;
            sg_q     <= 1'b0;
            sg_a     <= 1'b0;
            dz       <= 1'b0;
            op_div_r <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state    <= bus.Funct[1] ? MD_DIV : MD_MUL;
                        op_div_r <= bus.Funct[1];
                        sg_q     <= op_signed && (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                        sg_a     <= op_signed && bus.SrcA[WIDTH-1];
                        dz       <= (bus.SrcB == '0);
                    end
                    if (mt_hi) hi_r <= bus.SrcA;
                    if (mt_lo) lo_r <= bus.SrcA;
                end
                MD_MUL, MD_DIV: begin
                    if (bus.Flush)    state <= MD_IDLE;
                    else if (it_done) state <= MD_FIX;
                end
                default: begin
                    state <= MD_IDLE;
                    if (!bus.Flush) begin
                        if (op_div_r) begin
                            hi_r <= rem_fix;
                            lo_r <= quot_fix;
                        end else begin
                            {hi_r, lo_r} <= prod_fix;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ALUControl   = alu_ctl;
    assign bus.IllegalFunct = bus.Valid && illegal_f;
    assign bus.MDWrite      = is_mf;
    assign bus.MDResult     = !is_mf ? '0 : (bus.Funct == FUNCT_MFHI) ? hi_r : lo_r;
    assign bus.Busy         = busy;
    assign bus.Stall        = stall;
endmodule

// File: tb/tb_alu_md_control.sv
// Bench for alu_md_control: decode table, MDU ops read back through a
// scoreboard of expected MFLO/MFHI values, flush and async reset cases.
module tb_alu_md_control;
    import alu_md_control_pkg::*;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    alu_md_control_if #(.WIDTH(W)) bus();

    alu_md_control #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #50 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Every MFHI/MFLO the DUT releases is matched against the scoreboard
    always @(negedge CLK) begin
        if (bus.MDWrite) begin
            if (sb_q.size() == 0) chk("sb_extra_mdwrite", bus.MDWrite, 1'b0);
            else                  chk("md_result", bus.MDResult, sb_q.pop_front());
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [1:0] op, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Valid = v;
        bus.ALUOp = op;
        bus.Funct = f;
        bus.SrcA  = a;
        bus.SrcB  = b;
    endtask

    task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] ctl,
                       input logic ill);
        set_op(1'b1, op, f, '0, '0);
        #1;
        chk("alu_control", bus.ALUControl, ctl);
        chk("illegal_funct", bus.IllegalFunct, ill);
    endtask

    // Independent reference for {HI, LO}
    function automatic logic [63:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            FUNCT_MULT:  return 64'(sa * sb);
            FUNCT_MULTU: return {32'b0, a} * {32'b0, b};
            default: begin
                if (b == '0) return {a, {W{1'b1}}};
                if (f == FUNCT_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic rd(input logic [5:0] f, input logic [W-1:0] e);
        sb_q.push_back(e);
        set_op(1'b1, ALU_DECODER_FUNCT, f, '0, '0);
        @(negedge CLK);
        chk("mdwrite_rd", bus.MDWrite, 1'b1);
        step();
        set_op(1'b0, 2'b00, 6'b0, '0, '0);
    endtask

    // Issue an MD op, follow with a dependent MFLO, then MFHI
    task automatic md_run(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] r;
        int n;
        r = model(f, a, b);
        m_hi = r[63:32];
        m_lo = r[31:0];
        sb_q.push_back(m_lo);
        set_op(1'b1, ALU_DECODER_FUNCT, f, a, b);
        @(negedge CLK);
        chk("accept_stall", bus.Stall, 1'b0);
        step();
        set_op(1'b1, ALU_DECODER_FUNCT, FUNCT_MFLO, '0, '0);
        n = 0;
        @(negedge CLK);
        while (bus.Stall && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("stall_cycles", 64'(n), 64'(W + 1));
        chk("busy_released", bus.Busy, 1'b0);
        chk("mdwrite_released", bus.MDWrite, 1'b1);
        step();
        rd(FUNCT_MFHI, m_hi);
    endtask

    initial begin
        bus.Flush = 1'b0;
        set_op(1'b0, 2'b00, 6'b0, '0, '0);
        #120;
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_stall", bus.Stall, 1'b0);
        chk("rst_mdwrite", bus.MDWrite, 1'b0);
        chk("rst_mdresult", bus.MDResult, '0);
        RESET_N = 1'b1;
        step();

        dec(2'b00, 6'b111111, 4'b0010, 1'b0);
        dec(2'b01, 6'b111111, 4'b0110, 1'b0);
        dec(2'b11, 6'b000000, 4'b0001, 1'b0);
        dec(2'b10, 6'b100000, 4'b0010, 1'b0);
        dec(2'b10, 6'b100011, 4'b0110, 1'b0);
        dec(2'b10, 6'b100100, 4'b0000, 1'b0);
        dec(2'b10, 6'b100101, 4'b0001, 1'b0);
        dec(2'b10, 6'b100110, 4'b0011, 1'b0);
        dec(2'b10, 6'b100111, 4'b1100, 1'b0);
        dec(2'b10, 6'b101010, 4'b0111, 1'b0);
        dec(2'b10, 6'b101011, 4'b1111, 1'b0);
        dec(2'b10, 6'b000000, 4'b1000, 1'b0);
        dec(2'b10, 6'b000010, 4'b1001, 1'b0);
        dec(2'b10, 6'b000011, 4'b1010, 1'b0);
        dec(2'b10, 6'b011010, 4'b0010, 1'b0);
        dec(2'b10, 6'b111111, 4'b0010, 1'b1);
        dec(2'b10, 6'b000001, 4'b0010, 1'b1);
        bus.Valid = 1'b0;
        #1;
        chk("illegal_no_valid", bus.IllegalFunct, 1'b0);
        step();

        rd(FUNCT_MFHI, '0);
        md_run(FUNCT_MULT,  32'hFFFF_FFFD, 32'd7);
        md_run(FUNCT_DIVU,  32'd100, 32'd7);
        md_run(FUNCT_DIV,   32'hFFFF_FFF9, 32'd2);
        md_run(FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        md_run(FUNCT_DIV,   32'd5, 32'd0);
        md_run(FUNCT_MULTU, $urandom, $urandom);
        md_run(FUNCT_DIV,   $urandom, $urandom_range(1, 1000));

        // Flush on the accept edge: nothing starts
        set_op(1'b1, ALU_DECODER_FUNCT, FUNCT_MULT, 32'd3, 32'd4);
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        set_op(1'b0, 2'b00, 6'b0, '0, '0);
        @(negedge CLK);
        chk("flush_on_accept", bus.Busy, 1'b0);
        step();

        // MTHI then MULTU flushed on cycle 10; ADD while busy never stalls
        m_hi = 32'h1234;
        set_op(1'b1, ALU_DECODER_FUNCT, FUNCT_MTHI, 32'h1234, '0);
        step();
        set_op(1'b1, ALU_DECODER_FUNCT, FUNCT_MULTU, 32'd3, 32'd4);
        step();
        set_op(1'b1, ALU_DECODER_FUNCT, FUNCT_ADD, 32'd1, 32'd2);
        @(negedge CLK);
        chk("add_no_stall", bus.Stall, 1'b0);
        chk("busy_running", bus.Busy, 1'b1);
        step();
        set_op(1'b0, 2'b00, 6'b0, '0, '0);
        repeat (8) step();
        bus.Flush = 1'b1;
        @(negedge CLK);
        chk("busy_before_flush", bus.Busy, 1'b1);
        step();
        bus.Flush = 1'b0;
        @(negedge CLK);
        chk("busy_after_flush", bus.Busy, 1'b0);
        step();
        rd(FUNCT_MFHI, m_hi);
        rd(FUNCT_MFLO, m_lo);

        // Asynchronous reset in the middle of a divide
        set_op(1'b1, ALU_DECODER_FUNCT, FUNCT_DIV, 32'd100, 32'd3);
        step();
        set_op(1'b1, ALU_DECODER_FUNCT, FUNCT_MFLO, '0, '0);
        repeat (5) step();
        @(negedge CLK);
        chk("stall_mid_div", bus.Stall, 1'b1);
        #10;
        RESET_N = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        chk("async_rst_busy", bus.Busy, 1'b0);
        chk("async_rst_stall", bus.Stall, 1'b0);
        chk("async_rst_lo", bus.MDResult, '0);
        sb_q.push_back(m_lo);
        step();
        RESET_N = 1'b1;
        @(negedge CLK);
        step();
        rd(FUNCT_MFHI, m_hi);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_md_control.md
Name: alu_md_control

Overview:
- Second-generation ALU control for the MIPS datapath.
- Decodes ALUOp/Funct into an extended 4-bit ALUControl, covering shifts, XOR/NOR and SLTU.
- Contains a multi-cycle multiply/divide unit (MDU) with HI/LO registers for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Sits between the main decoder and the execute stage; drives a Stall request to the hazard unit.

Parameters:
WIDTH, 32, datapath width; even, >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
Valid  in  1  instruction in decode/execute is real (not a bubble)
Flush  in  1  kill in-flight MDU operation
ALUOp  in  2  00 add, 01 subtract, 10 use Funct, 11 OR (ori)
Funct  in  6  R-type funct field
SrcA  in  WIDTH  rs operand
SrcB  in  WIDTH  rt operand
ALUControl  out  4  ALU operation code
MDWrite  out  1  instruction writes rd from MDU (MFHI/MFLO)
MDResult  out  WIDTH  HI or LO value for MFHI/MFLO
Busy  out  1  MDU iterating
Stall  out  1  hold decode/execute this cycle
IllegalFunct  out  1  ALUOp=10 with unsupported Funct

Behaviour:
- ALUControl is combinational:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 1000, SRL 1001, SRA 1010, NOR 1100, SUB 0110, SLT 0111, SLTU 1111.
  - The low 3 bits of AND/OR/ADD/SUB/SLT match the first-generation codes.
- Funct map: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA.
- MD functs: 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO, 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU. For these, ALUControl = ADD.
- Unknown funct: ALUControl = ADD and IllegalFunct = 1 (only when Valid). No simulation messages.
- MD op: Valid & ALUOp=10 & Funct is one of the eight MD codes.
- Stall = MD op & (Busy | state != IDLE). Non-MD instructions never stall.
- Reset (async, any state): state IDLE, HI=0, LO=0, counter 0, Busy 0. Outputs settle to Stall 0, MDWrite 0, MDResult 0.
- FSM states:
  - IDLE: an unstalled MULT/DIV (signed or unsigned) on a clock edge latches |SrcA| and |SrcB|, or raw values if unsigned. It also records the result signs and goes to MUL or DIV. That instruction itself is not stalled.
  - MUL: shift-add, 1 bit/cycle, WIDTH cycles, 2*WIDTH-bit accumulator.
  - DIV: restoring division, 1 quotient bit/cycle, WIDTH cycles.
  - FIX: one cycle applying sign correction, then writes HI/LO and returns to IDLE.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Latency: Busy high for exactly WIDTH+1 cycles after the accept edge. HI/LO update on the FIX→IDLE edge. A dependent MFHI/MFLO is released the cycle Busy falls.
- Results:
  - Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits.
  - Divide by zero: LO = all ones, HI = dividend. Same latency, no exception.
  - Signed most-negative ÷ -1: LO = most-negative, HI = 0.
- MTHI/MTLO (unstalled) write SrcA to HI/LO at the clock edge.
- MFHI/MFLO (unstalled): MDWrite = 1 and MDResult = HI/LO combinationally. Otherwise MDResult = 0.
- Flush while not IDLE: return to IDLE next edge, HI/LO unchanged, Busy falls. Flush in IDLE has no effect.
- Flush and accept on the same edge: Flush wins, no op is started.

Decomposition:
- Shared include (extends funct.v/ALU.v style defines):
  - `ALU_*` 4-bit codes
  - `FUNCT_*` 6-bit codes, including MD codes
  - `ALU_DECODER_*` ALUOp codes, adding 2'b11 OR
  - MDU state encodings
- One sub-module, md_iter, holds the datapath: operand, accumulator and counter registers, and the multiply/divide step logic. It takes start/op/signed inputs and returns done, hi, lo.
- alu_md_control holds the decoder, FSM control, HI/LO and Stall.

Test Plan:
- ALUOp=10, Funct=100111 → ALUControl=1100, IllegalFunct=0. Funct=111111 with Valid → ALUControl=0010, IllegalFunct=1.
- MULT SrcA=0xFFFFFFFD (-3), SrcB=7, then MFLO the next cycle → Stall high for 33 cycles, then MDWrite=1, MDResult=0xFFFFFFEB. MFHI → 0xFFFFFFFF.
- DIVU 100/7 → LO=14, HI=2. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 5/0 → after 33 cycles LO=0xFFFFFFFF, HI=5.
- MTHI 0x1234 then MULTU 3×4, Flush asserted on cycle 10 → Busy falls the next cycle, HI stays 0x1234. ADD issued during Busy → Stall=0.
- RESET_N pulsed low mid-DIV (asynchronously, between edges) → Busy, Stall, HI and LO are 0 immediately.
